// File: rtl/vga_text_pkg.sv
// ---------------------------------------------------------------------------
// vga_text_pkg
// Shared definitions for the 80x25 text-mode renderer: console geometry,
// the 16-entry CGA palette (12-bit {r,g,b}), the attribute byte layout and
// the per-pixel side-band that travels down the render pipeline.
// ---------------------------------------------------------------------------
package vga_text_pkg;

  localparam int unsigned COLS   = 80;
  localparam int unsigned ROWS   = 25;
  localparam int unsigned CELL_W = 9;
  localparam int unsigned CELL_H = 16;

  // Entry 15 first, entry 0 last.
  localparam logic [15:0][11:0] PALETTE = {
    12'hFFF, 12'hFF5, 12'hF5F, 12'hF55,
    12'h5FF, 12'h5F5, 12'h55F, 12'h555,
    12'hAAA, 12'hA50, 12'hA0A, 12'hA00,
    12'h0AA, 12'h0A0, 12'h00A, 12'h000
  };

  typedef struct packed {
    logic       blink;
    logic [2:0] bg;
    logic [3:0] fg;
  } attr_t;

  // Side-band carried alongside each pixel through the fetch stages.
  typedef struct packed {
    logic [3:0] dot;
    logic       oor;
    logic       hs;
    logic       vs;
    logic       act;
  } side_t;

  function automatic logic [11:0] palette_lookup(input logic [3:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/vga_text_cellctr.sv
// ---------------------------------------------------------------------------
// vga_text_cellctr
// Tracks the dot (0..8) and column (0..127, saturating) of the incoming pixel
// and forms the text RAM word address row*80+col.
//   clock, rst_i  : pixel clock, synchronous active-high reset
//   active_i      : active-video flag; clears both counters when low
//   row_i         : character row of the current pixel
//   dot_o, col_o  : position of the current pixel inside the line
//   adr_o         : unregistered address of the current pixel's cell
//   text_adr_o    : registered address presented to the text RAM
// ---------------------------------------------------------------------------
module vga_text_cellctr
  import vga_text_pkg::*;
(
  input  logic        clock,
  input  logic        rst_i,
  input  logic        active_i,
  input  logic [4:0]  row_i,
  output logic [3:0]  dot_o,
  output logic [6:0]  col_o,
  output logic [10:0] adr_o,
  output logic [10:0] text_adr_o
);

  logic [3:0]  dot_q, dot_d;
  logic [6:0]  col_q, col_d;
  logic [10:0] row_w;
  logic [10:0] adr_d;
  logic [10:0] text_adr_q;

  always_comb begin
    dot_d = dot_q;
    col_d = col_q;
    if (!active_i) begin
      dot_d = '0;
      col_d = '0;
    end else if (dot_q == 4'(CELL_W - 1)) begin
      dot_d = '0;
      // Saturate so pixels past the last column stay out of range.
      if (col_q != '1) col_d = col_q + 7'd1;
    end else begin
      dot_d = dot_q + 4'd1;
    end
  end

  // row*80 = row*64 + row*16
  assign row_w = {6'b0, row_i};
  assign adr_d = (row_w << 6) + (row_w << 4) + {4'b0, col_q};

  always_ff @(posedge clock) begin
    if (rst_i) begin
      dot_q      <= '0;
      col_q      <= '0;
      text_adr_q <= '0;
    end else begin
      dot_q      <= dot_d;
      col_q      <= col_d;
      text_adr_q <= adr_d;
    end
  end

  assign dot_o      = dot_q;
  assign col_o      = col_q;
  assign adr_o      = adr_d;
  assign text_adr_o = text_adr_q;

endmodule

// File: rtl/vga_text_render.sv
// ---------------------------------------------------------------------------
// vga_text_render
// Renders an 80x25 text console (9x16 cells) from 720x400 VGA timing.
// Pipeline: text RAM fetch -> font ROM fetch -> palette, fixed 4-clock
// latency; hs/vs/active are delayed to match the RGB output.
//   clock, rst_i           : pixel clock, synchronous active-high reset
//   active_i, x_i, y_i     : timing-generator position (x_i is debug only)
//   hs_i, vs_i             : syncs in (vs low = sync pulse)
//   text_adr_o/text_dat_i  : text RAM, 1-cycle read, {attr, char}
//   font_adr_o/font_dat_i  : font ROM, 1-cycle read, bit 7 = leftmost dot
//   r_o, g_o, b_o          : 4-bit colour channels
//   hs_o, vs_o, active_o   : syncs/active delayed 4 clocks
// Optional: VGA_TEXT_CURSOR_EN adds cursor_pos_i and an underline cursor on
// lines 14..15 of the addressed cell, blinking with frame counter bit 3.
// ---------------------------------------------------------------------------
module vga_text_render
  import vga_text_pkg::*;
#(
  parameter int unsigned COLS      = vga_text_pkg::COLS,
  parameter int unsigned ROWS      = vga_text_pkg::ROWS,
  parameter int unsigned BLINK_BIT = 4
) (
  input  logic        clock,
  input  logic        rst_i,
  input  logic        active_i,
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic        hs_i,
  input  logic        vs_i,
`ifdef VGA_TEXT_CURSOR_EN
  input  logic [10:0] cursor_pos_i,
`endif
  output logic [10:0] text_adr_o,
  input  logic [15:0] text_dat_i,
  output logic [11:0] font_adr_o,
  input  logic [7:0]  font_dat_i,
  output logic [3:0]  r_o,
  output logic [3:0]  g_o,
  output logic [3:0]  b_o,
  output logic        hs_o,
  output logic        vs_o,
  output logic        active_o
);

  localparam int unsigned LINE_W = $clog2(CELL_H);

  logic [4:0]  row;
  logic [3:0]  line;
  logic [3:0]  dot;
  logic [6:0]  col;
  logic [10:0] cell_adr;

  logic        unused_in;
  assign unused_in = ^{x_i, y_i[15:LINE_W+5]};

  assign line = y_i[LINE_W-1:0];
  assign row  = y_i[LINE_W +: 5];

  vga_text_cellctr u_cellctr (
    .clock      (clock),
    .rst_i      (rst_i),
    .active_i   (active_i),
    .row_i      (row),
    .dot_o      (dot),
    .col_o      (col),
    .adr_o      (cell_adr),
    .text_adr_o (text_adr_o)
  );

  side_t       s1_d, s1_q, s2_q, s3_q, s4_q;
  logic [3:0]  line1_q, line2_q;
  attr_t       attr3_q, attr4_q;
  logic        ext_d, ext3_q, ext4_q;
  logic [11:0] font_adr_d, font_adr_q;
  logic        fg_on;
  logic [3:0]  pal_idx;
  logic [11:0] rgb_d, rgb_q;
  logic        hs_q, vs_out_q, act_q;
  logic        vs_dly_q;
  logic [4:0]  frame_cnt_d, frame_cnt_q;

  always_comb begin
    s1_d.dot = dot;
    s1_d.oor = !active_i || (col >= 7'(COLS)) || (row >= 5'(ROWS));
    s1_d.hs  = hs_i;
    s1_d.vs  = vs_i;
    s1_d.act = active_i;
  end

  assign font_adr_d = {text_dat_i[7:0], line2_q};
  // Box-drawing range 0xC0..0xDF extends its rightmost dot into the gap column.
  assign ext_d      = (text_dat_i[7:5] == 3'b110);

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (vs_dly_q && !vs_i) frame_cnt_d = frame_cnt_q + 5'd1;
  end

`ifdef VGA_TEXT_CURSOR_EN
  logic       cur_d;
  logic [3:0] cur_q;
  assign cur_d = (cell_adr == cursor_pos_i) && (line >= 4'(CELL_H - 2));
`else
  logic unused_adr;
  assign unused_adr = ^cell_adr;
`endif

  always_comb begin
    fg_on = s4_q.dot[3] ? (ext4_q & font_dat_i[0]) : font_dat_i[~s4_q.dot[2:0]];
    if (attr4_q.blink && frame_cnt_q[BLINK_BIT]) fg_on = 1'b0;
`ifdef VGA_TEXT_CURSOR_EN
    if (cur_q[3] && frame_cnt_q[3]) fg_on = 1'b1;
`endif
    pal_idx = fg_on ? attr4_q.fg : {1'b0, attr4_q.bg};
    rgb_d   = s4_q.oor ? '0 : palette_lookup(pal_idx);
  end

  always_ff @(posedge clock) begin
    if (rst_i) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      s4_q        <= '0;
      line1_q     <= '0;
      line2_q     <= '0;
      attr3_q     <= '0;
      attr4_q     <= '0;
      ext3_q      <= '0;
      ext4_q      <= '0;
      font_adr_q  <= '0;
      rgb_q       <= '0;
      hs_q        <= '0;
      vs_out_q    <= '0;
      act_q       <= '0;
      vs_dly_q    <= '0;
      frame_cnt_q <= '0;
`ifdef VGA_TEXT_CURSOR_EN
      cur_q       <= '0;
`endif
    end else begin
      s1_q        <= s1_d;
      line1_q     <= line;
      s2_q        <= s1_q;
      line2_q     <= line1_q;
      s3_q        <= s2_q;
      font_adr_q  <= font_adr_d;
      attr3_q     <= attr_t'(text_dat_i[15:8]);
      ext3_q      <= ext_d;
      s4_q        <= s3_q;
      attr4_q     <= attr3_q;
      ext4_q      <= ext3_q;
      rgb_q       <= rgb_d;
      hs_q        <= s4_q.hs;
      vs_out_q    <= s4_q.vs;
      act_q       <= s4_q.act;
      vs_dly_q    <= vs_i;
      frame_cnt_q <= frame_cnt_d;
`ifdef VGA_TEXT_CURSOR_EN
      cur_q       <= {cur_q[2:0], cur_d};
`endif
    end
  end

  assign font_adr_o = font_adr_q;
  assign r_o        = rgb_q[11:8];
  assign g_o        = rgb_q[7:4];
  assign b_o        = rgb_q[3:0];
  assign hs_o       = hs_q;
  assign vs_o       = vs_out_q;
  assign active_o   = act_q;

endmodule

// File: tb/tb_vga_text_render.sv
module tb_vga_text_render;

  logic        clock;
  logic        rst_i, active_i, hs_i, vs_i;
  logic [15:0] x_i, y_i;
  logic [10:0] text_adr_o;
  logic [15:0] text_dat_i;
  logic [11:0] font_adr_o;
  logic [7:0]  font_dat_i;
  logic [3:0]  r_o, g_o, b_o;
  logic        hs_o, vs_o, active_o;
`ifdef VGA_TEXT_CURSOR_EN
  logic [10:0] cursor_pos_i;
`endif

  logic [15:0] tram [2048];
  logic [7:0]  from [4096];
  logic [14:0] sb [$];
  logic [14:0] obs;
  logic [4:0]  fcnt;
  logic        vs_last;
  int unsigned errors, checks;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    text_dat_i <= tram[text_adr_o];
    font_dat_i <= from[font_adr_o];
  end

  assign obs = {r_o, g_o, b_o, hs_o, vs_o, active_o};

  vga_text_render #(.COLS(80), .ROWS(25), .BLINK_BIT(4)) dut (
    .clock        (clock),
    .rst_i        (rst_i),
    .active_i     (active_i),
    .x_i          (x_i),
    .y_i          (y_i),
    .hs_i         (hs_i),
    .vs_i         (vs_i),
`ifdef VGA_TEXT_CURSOR_EN
    .cursor_pos_i (cursor_pos_i),
`endif
    .text_adr_o   (text_adr_o),
    .text_dat_i   (text_dat_i),
    .font_adr_o   (font_adr_o),
    .font_dat_i   (font_dat_i),
    .r_o          (r_o),
    .g_o          (g_o),
    .b_o          (b_o),
    .hs_o         (hs_o),
    .vs_o         (vs_o),
    .active_o     (active_o)
  );

  function automatic logic [11:0] pal(input logic [3:0] i);
    case (i)
      4'h0: return 12'h000;  4'h1: return 12'h00A;
      4'h2: return 12'h0A0;  4'h3: return 12'h0AA;
      4'h4: return 12'hA00;  4'h5: return 12'hA0A;
      4'h6: return 12'hA50;  4'h7: return 12'hAAA;
      4'h8: return 12'h555;  4'h9: return 12'h55F;
      4'hA: return 12'h5F5;  4'hB: return 12'h5FF;
      4'hC: return 12'hF55;  4'hD: return 12'hF5F;
      4'hE: return 12'hFF5;  default: return 12'hFFF;
    endcase
  endfunction

  // Expected {rgb, hs, vs, active} for one input pixel, from screen geometry.
  function automatic logic [14:0] model(input logic act, input logic hs, input logic vs,
                                        input int unsigned y, input int unsigned x);
    int unsigned col, dot, row, line, adr, fa;
    logic [15:0] w;
    logic [7:0]  g;
    logic        on;
    logic [11:0] rgb;
    col = x / 9;
    dot = x % 9;
    row = (y / 16) % 32;
    line = y % 16;
    rgb = 12'h000;
    if (act && col < 80 && row < 25) begin
      adr = row * 80 + col;
      w = tram[adr];
      fa = 32'(w[7:0]) * 16 + line;
      g = from[fa];
      if (dot < 8) on = g[7 - dot];
      else on = (w[7:0] >= 8'hC0 && w[7:0] <= 8'hDF) ? g[0] : 1'b0;
      if (w[15] && fcnt[4]) on = 1'b0;
`ifdef VGA_TEXT_CURSOR_EN
      if (adr == 32'(cursor_pos_i) && line >= 14 && fcnt[3]) on = 1'b1;
`endif
      rgb = pal(on ? w[11:8] : {1'b0, w[14:12]});
    end
    return {rgb, hs, vs, act};
  endfunction

  task automatic put(input logic act, input logic hs, input logic vs,
                     input int unsigned y, input int unsigned x);
    active_i = act;
    hs_i     = hs;
    vs_i     = vs;
    y_i      = 16'(y);
    x_i      = 16'(x);
    if (vs_last && !vs) fcnt = fcnt + 5'd1;
    vs_last = vs;
    sb.push_back(model(act, hs, vs, y, x));
  endtask

  task automatic test_reset(input string tag);
    @(negedge clock);
    rst_i = 1'b1; active_i = 1'b0; hs_i = 1'b1; vs_i = 1'b1; x_i = '0; y_i = '0;
    sb.delete();
    for (int unsigned i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (obs !== 15'h0 || text_adr_o !== 11'h0 || font_adr_o !== 12'h0) begin
        errors++;
        $display("FAIL %s: out/text_adr/font_adr got %h/%h/%h want 0/0/0",
                 tag, obs, text_adr_o, font_adr_o);
      end
    end
    @(negedge clock);
    rst_i = 1'b0;
    fcnt = '0;
    vs_last = 1'b0;
    repeat (4) sb.push_back(15'h0);
    put(1'b0, 1'b1, 1'b1, 0, 0);
  endtask

  task automatic test_glyph();
    logic [14:0] e;
    for (int unsigned i = 0; i < 18; i++) begin
      @(negedge clock);
      if (sb.size() == 5) begin
        e = sb.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL glyph cyc=%0d: got %h want %h", i, obs, e); end
      end
      if (i < 10) put(1'b1, 1'b1, 1'b1, 0, i);
      else put(1'b0, i != 12, 1'b1, 0, 0);
    end
  endtask

  task automatic test_last_cell();
    logic [14:0] e;
    int unsigned n, y;
    for (int unsigned ln = 0; ln < 2; ln++) begin
      n = (ln == 0) ? 729 : 18;
      y = (ln == 0) ? 399 : 400;
      for (int unsigned i = 0; i < n + 6; i++) begin
        @(negedge clock);
        if (sb.size() == 5) begin
          e = sb.pop_front(); checks++;
          if (obs !== e) begin errors++; $display("FAIL last_cell y=%0d cyc=%0d: got %h want %h", y, i, obs, e); end
        end
        if (ln == 0 && i == 712) begin
          checks++;
          if (text_adr_o !== 11'd1999) begin errors++; $display("FAIL text_adr_1999: got %0d want 1999", text_adr_o); end
        end
        if (ln == 0 && i == 714) begin
          checks++;
          if (font_adr_o !== 12'hDBF) begin errors++; $display("FAIL font_adr: got %h want dbf", font_adr_o); end
        end
        if (i < n) put(1'b1, 1'b1, 1'b1, y, i);
        else put(1'b0, i != n + 2, 1'b1, y, 0);
      end
    end
  endtask

  task automatic test_dot8();
    logic [14:0] e;
    for (int unsigned i = 0; i < 114; i++) begin
      @(negedge clock);
      if (sb.size() == 5) begin
        e = sb.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL dot8 cyc=%0d: got %h want %h", i, obs, e); end
      end
      if (i < 108) put(1'b1, 1'b1, 1'b1, 2, i);
      else put(1'b0, i != 110, 1'b1, 2, 0);
    end
  endtask

  task automatic test_blink();
    logic [14:0] e;
    for (int unsigned p = 0; p < 3; p++) begin
      for (int unsigned i = 0; i < 32 + 195; i++) begin
        @(negedge clock);
        if (sb.size() == 5) begin
          e = sb.pop_front(); checks++;
          if (obs !== e) begin errors++; $display("FAIL blink phase=%0d cyc=%0d: got %h want %h", p, i, obs, e); end
        end
        if (i < 32) put(1'b0, 1'b1, (p == 0) ? 1'b1 : i[0], 0, 0);
        else if (i < 32 + 189) put(1'b1, 1'b1, 1'b1, 0, i - 32);
        else put(1'b0, 1'b1, 1'b1, 0, 0);
      end
    end
  endtask

`ifdef VGA_TEXT_CURSOR_EN
  task automatic test_cursor();
    logic [14:0] e;
    cursor_pos_i = 11'd5;
    for (int unsigned ln = 0; ln < 4; ln++) begin
      for (int unsigned i = 0; i < ((ln == 0) ? 16 : 60); i++) begin
        @(negedge clock);
        if (sb.size() == 5) begin
          e = sb.pop_front(); checks++;
          if (obs !== e) begin errors++; $display("FAIL cursor ln=%0d cyc=%0d: got %h want %h", ln, i, obs, e); end
        end
        if (ln == 0) put(1'b0, 1'b1, i[0], 0, 0);
        else if (i < 54) put(1'b1, 1'b1, 1'b1, 12 + ln, i);
        else put(1'b0, 1'b1, 1'b1, 12 + ln, 0);
      end
    end
  endtask
`endif

  task automatic test_midframe_reset();
    logic [14:0] e;
    for (int unsigned i = 0; i < 30; i++) begin
      @(negedge clock);
      if (sb.size() == 5) begin
        e = sb.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL pre_reset cyc=%0d: got %h want %h", i, obs, e); end
      end
      put(1'b1, 1'b1, 1'b1, 0, i);
    end
    test_reset("reset_mid");
  endtask

  task automatic test_drain();
    logic [14:0] e;
    for (int unsigned i = 0; i < 6; i++) begin
      @(negedge clock);
      if (sb.size() == 5) begin
        e = sb.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL drain cyc=%0d: got %h want %h", i, obs, e); end
      end
      put(1'b0, 1'b1, 1'b1, 0, 0);
    end
  endtask

  initial begin
    rst_i = 1'b1; active_i = 1'b0; hs_i = 1'b1; vs_i = 1'b1; x_i = '0; y_i = '0;
    errors = 0; checks = 0; fcnt = '0; vs_last = 1'b0;
`ifdef VGA_TEXT_CURSOR_EN
    cursor_pos_i = 11'd5;
`endif
    for (int unsigned i = 0; i < 2048; i++) tram[i] = 16'h0000;
    for (int unsigned i = 0; i < 4096; i++) from[i] = 8'h00;
    tram[0]    = 16'h0741;
    tram[5]    = 16'h1741;
    tram[10]   = 16'h1EC4;
    tram[11]   = 16'h1741;
    tram[20]   = 16'h9FDB;
    tram[1999] = 16'h1EDB;
    tram[2000] = 16'h0FDB;
    from[12'h410] = 8'h18;
    from[12'h412] = 8'hFF;
    from[12'hC42] = 8'hFF;
    from[12'hDB0] = 8'hFF;
    from[12'hDBF] = 8'hFF;

    test_reset("reset");
    test_glyph();
    test_last_cell();
    test_dot8();
    test_blink();
`ifdef VGA_TEXT_CURSOR_EN
    test_cursor();
`endif
    test_midframe_reset();
    test_glyph();
    test_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_text_render.md
Name: vga_text_render

Overview:
- Downstream consumer of the 720x400@70Hz VGA timing generator; renders an 80x25 text console with 9x16 character cells.
- Turns timing (active/x/y/hs/vs) into text-RAM and font-ROM fetches, then into 12-bit RGB.
- hs/vs/active are delayed to stay aligned with the RGB output.
- Text RAM and font ROM are external synchronous-read memories with 1-cycle read latency.

Parameters:
COLS, 80, character columns
ROWS, 25, character rows
BLINK_BIT, 4, frame-counter bit that drives attribute blink (period 32 frames)

Ports:
clock  in  1  pixel clock (28 MHz)
rst_i  in  1  synchronous, active-high reset
active_i  in  1  timing-generator active-video flag
x_i  in  16  pixel x (unused internally except for debug; column is tracked locally)
y_i  in  16  pixel y, valid while active_i
hs_i  in  1  hsync from timing generator
vs_i  in  1  vsync from timing generator (low = sync pulse)
text_adr_o  out  11  text RAM word address = row*80+col
text_dat_i  in  16  [7:0] char code, [15:8] attribute
font_adr_o  out  12  font ROM address = char*16+line
font_dat_i  in  8  glyph row, bit 7 = leftmost dot
r_o, g_o, b_o  out  4 each  pixel colour
hs_o, vs_o, active_o  out  1 each  hs_i/vs_i/active_i delayed 4 cycles

Behaviour:
- Interface: single clock `clock`; `rst_i` is synchronous and active-high. Reset clears all registers; every output reads 0 after the reset edge, including the frame counter and the pipeline.
- Cell tracking: dot counter 0..8 and column counter 0..127.
  - active_i=0: both cleared.
  - active_i=1: dot increments; at dot=8 it wraps to 0 and column increments.
  - row = y_i[8:4], line = y_i[3:0].
- Pipeline (input sampled at edge N):
  - N: register text_adr_o, plus dot, line, out-of-range flag and sync bits.
  - N+1: RAM returns text_dat_i.
  - N+2: register font_adr_o and the attribute/char/dot side-band.
  - N+3: ROM returns font_dat_i.
  - N+4: register RGB, hs_o, vs_o, active_o.
  - Fixed latency is 4 clocks; no stalls.
- row*80 is computed as (row<<6)+(row<<4) in 11 bits.
- Out of range: when col>=COLS, row>=ROWS or active_i=0, RGB is forced to 0. Addresses are still driven but the result is don't-care.
- Dot select:
  - dot 0..7 uses font_dat_i[7-dot].
  - dot 8 replicates font_dat_i[0] when char is 0xC0..0xDF; otherwise it is 0 (background).
- Attribute:
  - fg index = attr[3:0]; bg index = {1'b0, attr[6:4]}.
  - attr[7]=1 with frame_cnt[BLINK_BIT]=1 shows bg for foreground dots.
- Colour: the selected 4-bit index maps through a fixed 16-entry CGA palette to 12-bit {r,g,b}.
- Frame counter: 5 bits, increments on each falling edge of vs_i (edge detect on a registered copy). Wraps 31->0.
- Reset mid-frame: the pipeline flushes to 0. Output resumes correctly from the next sampled input, with the first valid pixel 4 cycles later.

Optional Feature:
- Macro VGA_TEXT_CURSOR_EN.
- Defined:
  - Adds input `cursor_pos_i` [10:0].
  - The cell whose address equals cursor_pos_i shows foreground on all 9 dots of lines 14..15 while frame_cnt[3]=1.
  - The cursor overrides attribute blink; comparison is done at stage N and carried down the pipeline.
- Undefined: the port is absent and there is no cursor logic.

Decomposition:
- Package vga_text_pkg: COLS/ROWS/CELL_W=9/CELL_H=16 constants, a 16x12-bit palette constant, a typedef for the attribute struct {blink, bg[2:0], fg[3:0]}, and a palette lookup function.
- One sub-module is natural: vga_text_cellctr (dot/column counters plus address generation).

Test Plan:
- Reset with active_i=0 → all outputs 0; text_adr_o=0, font_adr_o=0.
- Row 0, RAM[0]=0x0741 ('A', grey on black), font row 0x18 → pixels at dots 3,4 give RGB 0xAAA, other dots 0x000; output appears exactly 4 cycles after the input.
- y_i=399 with col 79 → text_adr_o=24*80+79=1999. With col 80 (x beyond 720) → RGB 0.
- Char 0xC4 with font_dat_i=0xFF → dot 8 shows fg. Char 0x41 with font_dat_i=0xFF → dot 8 shows bg.
- attr=0x9F, after 16 vs_i falling edges (frame_cnt[4]=1) → fg dots render bg colour 0x00A. After 32 edges they render fg 0xFFF again.
- VGA_TEXT_CURSOR_EN, cursor_pos_i=5, frame_cnt[3]=1 → cell 5 lines 14,15 render solid fg on all 9 dots; line 13 renders normally.
